// File: rtl/clk_period_meter.sv
// Measures high/low phase lengths and period of an asynchronous divided clock
// in units of clk cycles, with sticky overflow and a period-stability lock flag.
module clk_period_meter #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);

    localparam int                MW        = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [MW-1:0]     MATCH_MAX = MW'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W:0]   prev_period;
    logic             prev_valid;
    logic [MW-1:0]    match_cnt;
    logic [CNT_W:0]   new_period;
    logic [MW-1:0]    next_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_comb begin
        new_period = {1'b0, high_lat} + {1'b0, cnt};
        next_match = '0;
        if (prev_valid && (new_period == prev_period))
            next_match = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            high_lat    <= '0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            period      <= '0;
            prev_period <= '0;
            prev_valid  <= 1'b0;
            match_cnt   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                cnt        <= '0;
                high_cnt   <= '0;
                low_cnt    <= '0;
                period     <= '0;
                prev_valid <= 1'b0;
                match_cnt  <= '0;
                locked     <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HIGH;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            high_lat <= cnt;
                            cnt      <= CNT_W'(1);
                            state    <= LOW;
                        end else if (cnt == CNT_MAX) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            overflow   <= 1'b1;
                            locked     <= 1'b0;
                            match_cnt  <= '0;
                            prev_valid <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            // Rise closes the period: publish and restart the high phase.
                            state       <= HIGH;
                            cnt         <= CNT_W'(1);
                            high_cnt    <= high_lat;
                            low_cnt     <= cnt;
                            period      <= new_period;
                            meas_valid  <= 1'b1;
                            prev_period <= new_period;
                            prev_valid  <= 1'b1;
                            match_cnt   <= next_match;
                            locked      <= (next_match == MATCH_MAX);
                        end else if (cnt == CNT_MAX) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            overflow   <= 1'b1;
                            locked     <= 1'b0;
                            match_cnt  <= '0;
                            prev_valid <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: timestamp-based reference model,
// expected measurements queued at publish time and popped by a monitor.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 4;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             locked;
    logic             overflow;

    clk_period_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .clr(clr),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
        .meas_valid(meas_valid), .locked(locked), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int per;
        bit lk;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    bit   jitter_mode = 1'b0;

    // Reference model state: edge timestamps of the synchronised signal.
    int unsigned tk;
    bit          p1, p2, p3;
    bit          armed, have_fall;
    int unsigned t_rise, t_fall, t_last;
    int          hist[$];
    int          m_high, m_low, m_per;
    bit          m_lock, m_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_drop_meas();
        armed     = 1'b0;
        have_fall = 1'b0;
        hist.delete();
        m_lock    = 1'b0;
    endtask

    task automatic model_reset();
        tk = 0;
        p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        model_drop_meas();
        m_high = 0; m_low = 0; m_per = 0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_publish(input int hi, input int lo);
        exp_t e;
        bit   same;
        hist.push_back(hi + lo);
        if (hist.size() > LOCK_COUNT) void'(hist.pop_front());
        same = (hist.size() == LOCK_COUNT);
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        m_high = hi; m_low = lo; m_per = hi + lo; m_lock = same;
        e.hi = hi; e.lo = lo; e.per = hi + lo; e.lk = same;
        exp_q.push_back(e);
    endtask

    task automatic model_edge();
        bit lvl, prv, r, f;
        tk++;
        lvl = p2; prv = p3;
        p3 = p2; p2 = p1; p1 = sig_in;
        r = lvl & ~prv;
        f = ~lvl & prv;
        if (clr) begin
            model_drop_meas();
            m_high = 0; m_low = 0; m_per = 0; m_ovf = 1'b0;
        end else if (r) begin
            if (armed && have_fall) model_publish(int'(t_fall - t_rise), int'(tk - t_fall));
            armed = 1'b1; have_fall = 1'b0; t_rise = tk; t_last = tk;
        end else if (f && armed && !have_fall) begin
            have_fall = 1'b1; t_fall = tk; t_last = tk;
        end else if (armed && (tk - t_last) >= CMAX) begin
            m_ovf = 1'b1;
            model_drop_meas();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_edge();
        end
    end

    // Monitor: pops expectations on meas_valid and checks held outputs each cycle.
    initial begin
        int win[$];
        int sum;
        exp_t e;
        forever begin
            @(negedge clk);
            check("meas_valid", meas_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (meas_valid) begin
                    check("pub_high", high_cnt, e.hi);
                    check("pub_low", low_cnt, e.lo);
                    check("pub_period", period, e.per);
                    check("pub_locked", locked, e.lk);
                end
            end
            check("hold_high", high_cnt, m_high);
            check("hold_low", low_cnt, m_low);
            check("hold_period", period, m_per);
            check("locked", locked, m_lock);
            check("overflow", overflow, m_ovf);
            if (!jitter_mode) win.delete();
            else if (meas_valid) begin
                check("jit_period_range", (period >= 6) && (period <= 8), 1);
                win.push_back(int'(period));
                if (win.size() > 7) void'(win.pop_front());
                if (win.size() == 7) begin
                    sum = 0;
                    foreach (win[i]) sum += win[i];
                    check("jit_sum7", (sum >= 48) && (sum <= 50), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input bit v, input bit c);
        @(negedge clk);
        sig_in = v;
        clr    = c;
    endtask

    task automatic drive_period(input int hi, input int lo);
        repeat (hi) step(1'b1, 1'b0);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    initial begin
        longint base, tr, tf;
        int     hi, lo;
        reset  = 1'b1;
        sig_in = 1'b0;
        clr    = 1'b0;
        @(negedge clk);
        #1;
        check("rst_high", high_cnt, 0);
        check("rst_low", low_cnt, 0);
        check("rst_period", period, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Stable 4/3, then switch to 4/4 while locked.
        repeat (8) drive_period(4, 3);
        check("s43_high", high_cnt, 4);
        check("s43_low", low_cnt, 3);
        check("s43_period", period, 7);
        check("s43_locked", locked, 1);
        repeat (6) drive_period(4, 4);
        check("s44_period", period, 8);
        check("s44_locked", locked, 1);

        // clr coincident with the rise seen by the measurement logic.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("clr_period", period, 0);
        check("clr_locked", locked, 0);
        repeat (4) step(1'b0, 1'b0);
        repeat (3) drive_period(4, 4);
        check("post_clr_period", period, 8);
        check("post_clr_locked", locked, 0);

        // Asynchronous reset in the middle of a high phase.
        repeat (3) step(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_high", high_cnt, 0);
        check("arst_low", low_cnt, 0);
        check("arst_period", period, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (3) drive_period(4, 3);

        // Overflow from a stuck-high input, then cleared by clr.
        repeat (300) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_locked", locked, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #1;
        check("ovf_cleared", overflow, 0);

        // Random duty cycles with occasional clr.
        for (int i = 0; i < 40; i++) begin
            hi = int'($urandom_range(1, 20));
            lo = int'($urandom_range(1, 20));
            for (int j = 0; j < hi + lo; j++)
                step(j < hi, $urandom_range(0, 60) == 0);
        end
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // 7-cycle period with random phase offset to clk.
        jitter_mode = 1'b1;
        base = $time + 20;
        for (int i = 0; i < 60; i++) begin
            tr = base + 70 * i + (longint'($urandom_range(0, 8)) - 4);
            #(tr - $time);
            sig_in = 1'b1;
            tf = base + 70 * i + 30 + (longint'($urandom_range(0, 8)) - 4);
            #(tf - $time);
            sig_in = 1'b0;
        end
        repeat (4) step(1'b0, 1'b0);
        jitter_mode = 1'b0;

        repeat (5) step(1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 8, width of each phase counter in clk cycles.
REQ-002 Parameter LOCK_COUNT, default 4, number of consecutive equal-period measurements required to assert locked.
REQ-003 Port clk, input, 1, fast sampling clock (PLL global clock); every register SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port sig_in, input, 1, external divided clock under measurement, asynchronous to clk.
REQ-006 Port clr, input, 1, synchronous clear of measurement state and status.
REQ-007 Port high_cnt, output, CNT_W, clk cycles sig_in was high in the last complete period.
REQ-008 Port low_cnt, output, CNT_W, clk cycles sig_in was low in the last complete period.
REQ-009 Port period, output, CNT_W+1, high_cnt+low_cnt of the last complete period.
REQ-010 Port meas_valid, output, 1, one-cycle pulse when high_cnt/low_cnt/period update.
REQ-011 Port locked, output, 1, period stable for LOCK_COUNT consecutive measurements.
REQ-012 Port overflow, output, 1, sticky: a phase exceeded counter range.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-014 Latency: sig_in sampled high at clk edge k SHALL produce rise during cycle k+1..k+2 and any resulting output update visible after edge k+2.
REQ-015 FSM states: IDLE, HIGH, LOW; reset and clr state SHALL be IDLE.
REQ-016 IDLE: ignore fall; on rise -> HIGH, phase counter := 1, no meas_valid (first partial period discarded).
REQ-017 HIGH: counter increments by 1 each cycle with no edge; on fall -> LOW, latch counter into internal high register, counter := 1.
REQ-018 LOW: counter increments each cycle with no edge; on rise -> HIGH, counter := 1, publish high_cnt := latched high, low_cnt := counter, period := latched high + counter (CNT_W+1-bit, no truncation), meas_valid := 1 for exactly one cycle.
REQ-019 Counts SHALL equal the number of clk cycles s2 held the level, i.e. a pulse held for N clk cycles yields N.
REQ-020 Overflow: in HIGH or LOW, if counter equals 2^CNT_W-1 and no edge occurs that cycle, overflow := 1 (sticky), locked := 0, match count := 0, state -> IDLE, no meas_valid.
REQ-021 Lock: on each publish, if new period equals previous published period, match count increments saturating at LOCK_COUNT-1, else match count := 0; locked SHALL be 1 exactly when match count = LOCK_COUNT-1 after the update (first measurement after IDLE never matches).
REQ-022 locked SHALL fall in the same cycle meas_valid reports a mismatching period.
REQ-023 clr SHALL, at the next clk edge, force IDLE, clear overflow, locked, match count and set high_cnt, low_cnt, period to 0; clr coincident with rise SHALL win (no meas_valid).
REQ-024 Outputs SHALL hold their values between meas_valid pulses.

Reset
REQ-025 reset SHALL asynchronously force s1, s2, s3 := 0, state IDLE, counter 0, high_cnt, low_cnt, period 0, meas_valid, locked, overflow 0, match count 0.
REQ-026 reset asserted mid-measurement SHALL discard the partial period; first meas_valid after release needs a rise, a fall and a second rise.

Verification
REQ-027 sig_in periodic 4 high / 3 low clk cycles -> first meas_valid after second rise with high_cnt=4, low_cnt=3, period=7; locked=1 on the 4th meas_valid.
REQ-028 Switch stable 4/3 to 4/4 while locked -> next meas_valid shows period=8 and locked=0 that cycle; locked returns after 4 further equal periods.
REQ-029 sig_in held high 300 cycles with CNT_W=8 -> overflow=1 after counter reaches 255, locked=0, no meas_valid; next clr clears overflow.
REQ-030 clr asserted in same cycle as rise during stable 4/4 stream -> no meas_valid, all outputs 0, next meas_valid only after a new full period.
REQ-031 reset pulse mid-HIGH phase -> all outputs 0 immediately (asynchronously); after release first meas_valid reports only a complete subsequent period.
REQ-032 sig_in toggling with random phase offset to clk, 7-cycle period -> every period output in {6,7,8}, sum over any 7 consecutive measurements within +/-1 of 49.
